// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with a start/done handshake.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bit_d, br_next;
    logic             load, last;

    assign load    = start && (state != RUN);
    assign last    = (state == RUN) && (cnt == LAST);
    assign bit_d   = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == LAST) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // The last RUN edge publishes the result including the bit computed on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= {bit_d, r_sr[WIDTH-1:1]};
            br   <= br_next;
            cnt  <= cnt + 1'b1;
            if (last) begin
                diff   <= {bit_d, r_sr[WIDTH-1:1]};
                borrow <= br_next;
            end
        end
    end

`ifdef SUB_OVERFLOW_EN
    // Operand sign bits are shifted out during RUN, so keep copies for the overflow test.
    logic a_msb, b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (last) begin
            overflow <= (a_msb != b_msb) && (bit_d != a_msb);
        end
    end
`endif

endmodule
